// File: rtl/symbol_grid_sequencer.sv
// Walks a ROWS x COLS board, hands each occupied cell's base (x,y) to the symbol
// drawer and gates plot; optional DRAW watchdog enabled by SEQ_WATCHDOG_EN.
module symbol_grid_sequencer #(
  parameter int unsigned COLS    = 4,
  parameter int unsigned ROWS    = 4,
  parameter int unsigned CELL_W  = 16,
  parameter int unsigned CELL_H  = 16,
  parameter int unsigned X0      = 16,
  parameter int unsigned Y0      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] occupied,
  input  logic                 sym_done,
  output logic                 draw_en,
  output logic [7:0]           base_x,
  output logic [6:0]           base_y,
  output logic                 plot,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned NCELLS = ROWS * COLS;
  localparam int unsigned IDXW   = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCELLS - 1);

  typedef enum logic [2:0] {IDLE, SCAN, DRAW, GAP, FIN} state_t;

  state_t            state, state_next;
  logic [NCELLS-1:0] mask;
  logic [IDXW-1:0]   idx;
  logic              timeout_hit;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;

  // wd_cnt counts completed DRAW cycles, so the abort lands on the TIMEOUT-th one
  assign timeout_hit = (state == DRAW) && !sym_done && (wd_cnt == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= (state == DRAW) ? wd_cnt + 1'b1 : '0;
      if (timeout_hit) err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = SCAN;
      SCAN: begin
        if (mask[idx])         state_next = DRAW;
        else if (idx == LAST)  state_next = FIN;
      end
      DRAW: if (sym_done || timeout_hit) state_next = GAP;
      GAP:  state_next = (idx == LAST) ? FIN : SCAN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask   <= '0;
      idx    <= '0;
      base_x <= 8'(X0);
      base_y <= 7'(Y0);
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask <= occupied;
            idx  <= '0;
          end
        end
        SCAN: begin
          base_x <= 8'(X0 + (32'(idx) % COLS) * CELL_W);
          base_y <= 7'(Y0 + (32'(idx) / COLS) * CELL_H);
          if (!mask[idx] && idx != LAST) idx <= idx + 1'b1;
        end
        GAP: begin
          if (idx != LAST) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign draw_en = (state == DRAW);
  assign plot    = (state == DRAW);
  assign busy    = (state != IDLE);
  assign done    = (state == FIN);

endmodule

// File: tb/tb_symbol_grid_sequencer.sv
// Self-checking bench for symbol_grid_sequencer: frame table plus scoreboard of
// expected draws; define SEQ_WATCHDOG_EN to also exercise the watchdog.
module tb_symbol_grid_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] occupied;
  logic        sym_done;
  logic        resp_done = 1'b0;
  logic        extra_done;
  logic        draw_en, plot, busy, done, err;
  logic [7:0]  base_x;
  logic [6:0]  base_y;

  assign sym_done = resp_done | extra_done;

  always #5 clk = ~clk;

  symbol_grid_sequencer #(
    .COLS(4), .ROWS(4), .CELL_W(16), .CELL_H(16), .X0(16), .Y0(8), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .occupied(occupied),
    .sym_done(sym_done), .draw_en(draw_en), .base_x(base_x), .base_y(base_y),
    .plot(plot), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int x;
    int y;
    int len;
    int d;
  } draw_t;

  typedef struct {
    logic [15:0] mask;
    int          d;
    int          exp_lat;
    int          exp_draws;
  } vec_t;

  draw_t exp_q[$];
  draw_t cur;
  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    draws = 0;
  int    dlen = 0;
  logic  prev_en = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Scoreboard consumer and drawer model: pops one expected draw per DRAW entry
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_en   = 1'b0;
      dlen      = 0;
      resp_done = 1'b0;
    end else if (draw_en && !prev_en) begin
      draws++;
      dlen = 1;
      if (exp_q.size() == 0) begin
        check("unexpected_draw", 1, 0);
        cur = '{0, 0, 1, 1};
      end else begin
        cur = exp_q.pop_front();
        check("base_x", int'(base_x), cur.x);
        check("base_y", int'(base_y), cur.y);
        check("plot", int'(plot), 1);
      end
      resp_done = (cur.d == 1);
      prev_en   = 1'b1;
    end else if (draw_en) begin
      dlen++;
      resp_done = (cur.d != 0) && (dlen == cur.d);
    end else begin
      if (prev_en) check("draw_len", dlen, cur.len);
      prev_en   = 1'b0;
      resp_done = 1'b0;
    end
  end

  task automatic push_frame(input logic [15:0] m, input int d_first, input int d_rest);
    bit first = 1'b1;
    int d;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        d = first ? d_first : d_rest;
        first = 1'b0;
        exp_q.push_back('{16 + 16 * (i % 4), 8 + 16 * (i / 4), (d == 0) ? 64 : d, d});
      end
    end
  endtask

  // Latency counts cycles from the start cycle through the done cycle inclusive
  task automatic run_frame(input logic [15:0] m, input int d_first, input int d_rest,
                           input int exp_lat, input int exp_draws, input bit inject,
                           input string tag);
    int n;
    int d0;
    d0 = draws;
    push_frame(m, d_first, d_rest);
    @(negedge clk);
    occupied = m;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 2;
    while (!done && n < 3000) begin
      if (inject && (n == 4 || n == 6)) begin
        start    = 1'b1;
        occupied = ~m;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, exp_lat);
    @(negedge clk);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_done_once"}, int'(done), 0);
    check({tag, "_draws"}, draws - d0, exp_draws);
    check({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{16'h0001, 51, 70, 1};
    vecs[1] = '{16'h8421, 3,  34, 4};
    vecs[2] = '{16'h0000, 1,  18, 0};
    vecs[3] = '{16'hFFFF, 1,  50, 16};
    vecs[4] = '{16'h8000, 2,  21, 1};

    reset_n    = 1'b0;
    start      = 1'b0;
    occupied   = '0;
    extra_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_draw_en", int'(draw_en), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_base_x", int'(base_x), 16);
    check("rst_base_y", int'(base_y), 8);
    reset_n = 1'b1;

    @(negedge clk);
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    @(negedge clk);
    check("idle_symdone_busy", int'(busy), 0);
    check("idle_symdone_draw", int'(draw_en), 0);

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].mask, vecs[v].d, vecs[v].d, vecs[v].exp_lat,
                vecs[v].exp_draws, 1'b0, $sformatf("vec%0d", v));
    end

    // start re-pulsed mid-DRAW (once alone, once with sym_done) and mask scrambled
    run_frame(16'h0003, 4, 4, 28, 2, 1'b1, "inject");

    push_frame(16'h0001, 0, 0);
    @(negedge clk);
    occupied = 16'h0001;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !draw_en; i++) @(negedge clk);
    check("reach_draw", int'(draw_en), 1);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_draw_en", int'(draw_en), 0);
    check("async_rst_plot", int'(plot), 0);
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
    run_frame(16'h0010, 2, 2, 21, 1, 1'b0, "after_reset");

`ifdef SEQ_WATCHDOG_EN
    check("wd_err_before", int'(err), 0);
    run_frame(16'h0003, 0, 2, 86, 2, 1'b0, "wd");
    check("wd_err_set", int'(err), 1);
    run_frame(16'h0000, 1, 1, 18, 0, 1'b0, "wd_sticky");
    check("wd_err_sticky", int'(err), 1);
`else
    check("err_tied", int'(err), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
